// File: rtl/jtag_scan_master.sv
// Host-side JTAG scan engine: walks the TAP from Run-Test/Idle through a DR/IR
// scan or a TAP reset, shifting data LSB first on tdi and collecting tdo.
module jtag_scan_master #(
    parameter int DATA_REG = 64,
    parameter int LEN_W    = 7
) (
    input  logic                tclk,
    input  logic                trst_n,
    input  logic                start,
    input  logic [1:0]          cmd,
    input  logic [LEN_W-1:0]    shift_len,
    input  logic [DATA_REG-1:0] data_in,
    input  logic                tdo,
    output logic                busy,
    output logic                done,
    output logic [DATA_REG-1:0] data_out,
    output logic                tck_o,
    output logic                tms,
    output logic                tdi
);

    localparam logic [3:0] S_AUTO_TLR = 4'd0;
    localparam logic [3:0] S_IDLE     = 4'd1;
    localparam logic [3:0] S_SEL_DR   = 4'd2;
    localparam logic [3:0] S_SEL_IR   = 4'd3;
    localparam logic [3:0] S_CAPTURE  = 4'd4;
    localparam logic [3:0] S_SHIFT    = 4'd5;
    localparam logic [3:0] S_EXIT1    = 4'd6;
    localparam logic [3:0] S_UPDATE   = 4'd7;
    localparam logic [3:0] S_FINISH   = 4'd8;

    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(DATA_REG);
    localparam logic [LEN_W-1:0] TLR_LAST = LEN_W'(5);
    localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);
    localparam logic [LEN_W-1:0] TWO      = LEN_W'(2);

    logic [3:0]          state_q, state_d;
    logic                phase_q, phase_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [DATA_REG-1:0] data_q, data_d;
    logic [DATA_REG-1:0] cap_q, cap_d;
    logic [DATA_REG-1:0] dout_q, dout_d;
    logic                tck_q, tck_d;
    logic                tms_q, tms_d;
    logic                tdi_q, tdi_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                fin_done_q, fin_done_d;
    logic                fin_scan_q, fin_scan_d;

    logic [LEN_W-1:0]    len_eff;
    logic                shifting;
    logic                tms_now;

    always_comb begin
        len_eff  = (shift_len > MAX_LEN) ? MAX_LEN : shift_len;
        shifting = (state_q == S_SHIFT) || (state_q == S_EXIT1);

        case (state_q)
            S_AUTO_TLR: tms_now = (cnt_q != TLR_LAST);
            S_SEL_DR,
            S_SEL_IR,
            S_EXIT1,
            S_UPDATE:   tms_now = 1'b1;
            default:    tms_now = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        data_d     = data_q;
        cap_d      = cap_q;
        dout_d     = dout_q;
        tck_d      = tck_q;
        tms_d      = tms_q;
        tdi_d      = tdi_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        fin_done_d = fin_done_q;
        fin_scan_d = fin_scan_q;

        if (state_q == S_IDLE) begin
            if (busy_q) begin
                // Trailing edge of a command: TCK's last high phase ends here.
                busy_d = 1'b0;
                done_d = fin_done_q;
                tck_d  = 1'b0;
                tdi_d  = 1'b0;
                if (fin_scan_q) begin
                    dout_d = cap_q >> (MAX_LEN - len_q);
                end
            end else if (start) begin
                busy_d     = 1'b1;
                phase_d    = 1'b0;
                cnt_d      = '0;
                fin_done_d = 1'b1;
                fin_scan_d = 1'b0;
                case (cmd)
                    2'b00,
                    2'b01: begin
                        if (len_eff != '0) begin
                            state_d    = cmd[0] ? S_SEL_IR : S_SEL_DR;
                            len_d      = len_eff;
                            data_d     = data_in;
                            cap_d      = '0;
                            fin_scan_d = 1'b1;
                        end
                    end
                    2'b10:   state_d = S_AUTO_TLR;
                    default: ;
                endcase
            end
        end else begin
            busy_d = 1'b1;
            if (!phase_q) begin
                phase_d = 1'b1;
                tck_d   = 1'b0;
                tms_d   = tms_now;
                tdi_d   = shifting ? data_q[0] : 1'b0;
            end else begin
                phase_d = 1'b0;
                tck_d   = 1'b1;
                // Captured bits enter at the top; realigned on completion.
                if (shifting) begin
                    cap_d  = {tdo, cap_q[DATA_REG-1:1]};
                    data_d = data_q >> 1;
                end
                case (state_q)
                    S_AUTO_TLR: begin
                        if (cnt_q == TLR_LAST) begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + ONE;
                        end
                    end
                    S_SEL_IR: state_d = S_SEL_DR;
                    S_SEL_DR: state_d = S_CAPTURE;
                    S_CAPTURE: begin
                        if (cnt_q == '0) begin
                            cnt_d = ONE;
                        end else begin
                            cnt_d   = '0;
                            state_d = (len_q == ONE) ? S_EXIT1 : S_SHIFT;
                        end
                    end
                    S_SHIFT: begin
                        cnt_d = cnt_q + ONE;
                        if (cnt_q == len_q - TWO) begin
                            state_d = S_EXIT1;
                        end
                    end
                    S_EXIT1:  state_d = S_UPDATE;
                    S_UPDATE: state_d = S_FINISH;
                    S_FINISH: state_d = S_IDLE;
                    default:  state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge tclk) begin
        if (!trst_n) begin
            state_q    <= S_AUTO_TLR;
            phase_q    <= 1'b0;
            cnt_q      <= '0;
            len_q      <= '0;
            data_q     <= '0;
            cap_q      <= '0;
            dout_q     <= '0;
            tck_q      <= 1'b0;
            tms_q      <= 1'b1;
            tdi_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fin_done_q <= 1'b0;
            fin_scan_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            data_q     <= data_d;
            cap_q      <= cap_d;
            dout_q     <= dout_d;
            tck_q      <= tck_d;
            tms_q      <= tms_d;
            tdi_q      <= tdi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fin_done_q <= fin_done_d;
            fin_scan_q <= fin_scan_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = dout_q;
    assign tck_o    = tck_q;
    assign tms      = tms_q;
    assign tdi      = tdi_q;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Scoreboard bench for jtag_scan_master against a behavioural JTAG TAP and
// a bit-stream reference model of each scan.
module tb_jtag_scan_master;

    localparam int DW = 64;
    localparam int LW = 7;

    logic          tclk = 1'b0;
    logic          trst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    cmd = 2'b00;
    logic [LW-1:0] shift_len = '0;
    logic [DW-1:0] data_in = '0;
    logic          tdo = 1'b0;
    logic          busy, done, tck_o, tms, tdi;
    logic [DW-1:0] data_out;

    jtag_scan_master #(.DATA_REG(DW), .LEN_W(LW)) dut (
        .tclk(tclk), .trst_n(trst_n), .start(start), .cmd(cmd),
        .shift_len(shift_len), .data_in(data_in), .tdo(tdo),
        .busy(busy), .done(done), .data_out(data_out),
        .tck_o(tck_o), .tms(tms), .tdi(tdi)
    );

    always #5 tclk = ~tclk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural TAP: 64-bit DR, 4-bit IR
    typedef enum int {
        TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
        SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR
    } tap_e;

    tap_e        tap = TLR;
    logic [63:0] dr_cap = '0, dr_sh = '0, dr_upd = '0;
    logic [3:0]  ir_cap = '0, ir_sh = '0, ir_upd = '0;

    function automatic tap_e tap_next(input tap_e s, input logic m);
        case (s)
            TLR:     return m ? TLR   : RTI;
            RTI:     return m ? SELDR : RTI;
            SELDR:   return m ? SELIR : CAPDR;
            CAPDR:   return m ? EX1DR : SHDR;
            SHDR:    return m ? EX1DR : SHDR;
            EX1DR:   return m ? UPDR  : PADR;
            PADR:    return m ? EX2DR : PADR;
            EX2DR:   return m ? UPDR  : SHDR;
            UPDR:    return m ? SELDR : RTI;
            SELIR:   return m ? TLR   : CAPIR;
            CAPIR:   return m ? EX1IR : SHIR;
            SHIR:    return m ? EX1IR : SHIR;
            EX1IR:   return m ? UPIR  : PAIR;
            PAIR:    return m ? EX2IR : PAIR;
            EX2IR:   return m ? UPIR  : SHIR;
            UPIR:    return m ? SELDR : RTI;
            default: return TLR;
        endcase
    endfunction

    always @(posedge tck_o) begin
        case (tap)
            CAPDR:   dr_sh = dr_cap;
            SHDR:    dr_sh = {tdi, dr_sh[63:1]};
            UPDR:    dr_upd = dr_sh;
            CAPIR:   ir_sh = ir_cap;
            SHIR:    ir_sh = {tdi, ir_sh[3:1]};
            UPIR:    ir_upd = ir_sh;
            default: ;
        endcase
        tap = tap_next(tap, tms);
    end

    always @(negedge tck_o) begin
        tdo = (tap == SHDR) ? dr_sh[0] : (tap == SHIR) ? ir_sh[0] : 1'b0;
    end

    // Scoreboard
    typedef struct {
        logic [63:0]  dout;
        int           n;
        logic [127:0] tms_v;
        logic [127:0] tdi_v;
    } exp_t;

    exp_t         sbq[$];
    exp_t         me;
    int           done_cnt = 0;
    int           rec_n = 0;
    logic [127:0] rec_tms = '0;
    logic [127:0] rec_tdi = '0;
    logic         tck_prev = 1'b0;

    always @(negedge tclk) begin
        if (!trst_n) begin
            rec_n   = 0;
            rec_tms = '0;
            rec_tdi = '0;
        end else begin
            if (done) begin
                done_cnt++;
                if (sbq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected none");
                end else begin
                    me = sbq.pop_front();
                    chk("tck_count", 128'(rec_n), 128'(me.n));
                    chk("tms_seq", rec_tms, me.tms_v);
                    chk("tdi_seq", rec_tdi, me.tdi_v);
                    chk("data_out", 128'(data_out), 128'(me.dout));
                end
                rec_n   = 0;
                rec_tms = '0;
                rec_tdi = '0;
            end else if (!busy) begin
                rec_n   = 0;
                rec_tms = '0;
                rec_tdi = '0;
            end
            if (tck_o && !tck_prev && rec_n < 128) begin
                rec_tms[rec_n[6:0]] = tms;
                rec_tdi[rec_n[6:0]] = tdi;
                rec_n++;
            end
        end
        tck_prev = tck_o;
    end

    // Reference model
    logic [63:0] mdl_dout = '0;
    logic [63:0] exp_dr = '0;
    logic [3:0]  exp_ir = '0;
    int          exp_kind = 0;

    task automatic send(input logic [1:0] c, input int len,
                        input logic [63:0] d);
        exp_t        e;
        int          n_eff, pre, idx, rl;
        logic [63:0] capv, upd;
        bit          q[$];
        n_eff    = (len > 64) ? 64 : len;
        e.n      = 0;
        e.tms_v  = '0;
        e.tdi_v  = '0;
        exp_kind = 0;
        if (c == 2'b10) begin
            e.n     = 6;
            e.tms_v = 128'h1F;
        end else if (c != 2'b11 && n_eff > 0) begin
            pre = (c == 2'b01) ? 2 : 1;
            idx = 0;
            for (int i = 0; i < pre; i++) begin
                e.tms_v[idx[6:0]] = 1'b1;
                idx++;
            end
            idx += 2;
            for (int k = 0; k < n_eff; k++) begin
                e.tdi_v[idx[6:0]] = d[k[5:0]];
                e.tms_v[idx[6:0]] = (k == n_eff - 1);
                idx++;
            end
            e.tms_v[idx[6:0]] = 1'b1;
            idx += 2;
            e.n = idx;
            rl   = (c == 2'b01) ? 4 : 64;
            capv = (c == 2'b01) ? {60'b0, ir_cap} : dr_cap;
            for (int i = 0; i < rl; i++) q.push_back(capv[i[5:0]]);
            for (int k = 0; k < n_eff; k++) q.push_back(d[k[5:0]]);
            mdl_dout = '0;
            for (int k = 0; k < n_eff; k++) mdl_dout[k[5:0]] = q[k];
            upd = '0;
            for (int i = 0; i < rl; i++) upd[i[5:0]] = q[n_eff + i];
            if (c == 2'b01) begin
                exp_ir   = upd[3:0];
                exp_kind = 2;
            end else begin
                exp_dr   = upd;
                exp_kind = 1;
            end
        end
        e.dout = mdl_dout;
        sbq.push_back(e);
        @(negedge tclk);
        cmd       = c;
        shift_len = LW'(len);
        data_in   = d;
        start     = 1'b1;
        @(negedge tclk);
        start     = 1'b0;
        data_in   = ~d;
        shift_len = ~LW'(len);
    endtask

    task automatic finish_cmd(input int budget);
        int c0;
        int i;
        c0 = done_cnt;
        for (i = 0; i < budget && done_cnt == c0; i++) @(negedge tclk);
        if (done_cnt == c0) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got no done expected done");
            sbq.delete();
        end
        if (exp_kind == 1) chk("dr_update", 128'(dr_upd), 128'(exp_dr));
        if (exp_kind == 2) chk("ir_update", 128'(ir_upd), 128'(exp_ir));
        chk("tap_in_idle", 128'(tap == RTI), 128'(1));
    endtask

    task automatic check_tlr();
        int          nbusy, nrise, ndone;
        logic [63:0] tv;
        logic        prev;
        trst_n = 1'b0;
        repeat (3) @(posedge tclk);
        #1;
        chk("rst_tck", 128'(tck_o), 128'(0));
        chk("rst_tms", 128'(tms), 128'(1));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_data_out", 128'(data_out), 128'(0));
        @(negedge tclk);
        trst_n = 1'b1;
        nbusy = 0;
        nrise = 0;
        ndone = 0;
        tv    = '0;
        prev  = tck_o;
        for (int i = 0; i < 16; i++) begin
            @(negedge tclk);
            if (busy) nbusy++;
            if (done) ndone++;
            if (tck_o && !prev) begin
                tv[nrise[5:0]] = tms;
                nrise++;
            end
            prev = tck_o;
        end
        chk("tlr_busy_cycles", 128'(nbusy), 128'(12));
        chk("tlr_tck_cycles", 128'(nrise), 128'(6));
        chk("tlr_tms_seq", 128'(tv), 128'h1F);
        chk("tlr_no_done", 128'(ndone), 128'(0));
        chk("tlr_tap_idle", 128'(tap == RTI), 128'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c0, rises, i;
        logic        prev;
        logic [1:0]  rc;
        int          rl;
        logic [63:0] rd;

        check_tlr();

        dr_cap = 64'h0123_4567_89AB_CDEF;
        send(2'b00, 64, 64'hA5A5_0F0F_1234_5678);
        finish_cmd(400);

        ir_cap = 4'b0001;
        send(2'b01, 4, 64'hA);
        finish_cmd(100);

        dr_cap = 64'h3C;
        send(2'b00, 8, '1);
        repeat (6) @(negedge tclk);
        cmd       = 2'b10;
        shift_len = LW'(5);
        start     = 1'b1;
        @(negedge tclk);
        start = 1'b0;
        finish_cmd(100);
        c0    = done_cnt;
        rises = 0;
        prev  = tck_o;
        for (int k = 0; k < 30; k++) begin
            @(negedge tclk);
            if (tck_o && !prev) rises++;
            prev = tck_o;
        end
        chk("guard_no_done", 128'(done_cnt - c0), 128'(0));
        chk("guard_no_tck", 128'(rises), 128'(0));

        send(2'b00, 0, 64'hDEAD_BEEF_0000_0001);
        finish_cmd(4);

        dr_cap = 64'hFEDC_BA98_7654_3210;
        send(2'b00, 100, 64'h1357_9BDF_2468_ACE0);
        finish_cmd(400);

        send(2'b11, 12, 64'h55);
        finish_cmd(4);

        send(2'b10, 0, '0);
        finish_cmd(40);

        dr_cap = 64'hCAFE_F00D_1234_4321;
        send(2'b00, 64, 64'h0F0F_F0F0_3333_CCCC);
        for (i = 0; i < 300 && rec_n < 23; i++) @(negedge tclk);
        if (rec_n < 23) begin
            n_tests++;
            n_fail++;
            $display("FAIL abort_reach: got %0d tck expected 23", rec_n);
        end
        trst_n = 1'b0;
        @(posedge tclk);
        #1;
        chk("abort_tck", 128'(tck_o), 128'(0));
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_done", 128'(done), 128'(0));
        chk("abort_data_out", 128'(data_out), 128'(0));
        sbq.delete();
        mdl_dout = '0;
        exp_kind = 0;
        check_tlr();

        for (int k = 0; k < 16; k++) begin
            rc     = 2'($urandom_range(0, 3));
            rl     = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5)
                                                 : $urandom_range(0, 100);
            rd     = {$urandom, $urandom};
            dr_cap = {$urandom, $urandom};
            ir_cap = 4'($urandom_range(0, 15));
            send(rc, rl, rd);
            finish_cmd(400);
        end

        repeat (4) @(negedge tclk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
